// File: rtl/dport_ctrl.sv
// Output-port controller: buffers CPU stores to PORT_ADDR in a FIFO, drains them to the
// dport sink over valid/ready, and raises done only once an end request has fully drained.
module dport_ctrl #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [15:0] PORT_ADDR = 16'hFFF0,
  parameter logic [15:0] DONE_ADDR = 16'hFFF1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic [7:0]  bus_wdata,
  input  logic        bus_we,
  output logic        bus_stall,
  output logic [7:0]  dport_out,
  output logic        dport_write,
  input  logic        dport_ready,
  output logic        done,
  output logic        err,
  output logic [8:0]  emitted
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] C_P_ONE = AW'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW:0]     r_count;
  logic            r_done;
  logic            r_err;
  logic [8:0]      r_emitted;

  logic            w_port_hit;
  logic            w_done_hit;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  assign w_port_hit = bus_we && (bus_addr == PORT_ADDR);
  assign w_done_hit = bus_we && (bus_addr == DONE_ADDR);
  assign w_full     = (r_count == C_FULL);
  // A full FIFO refuses the push even if the head leaves this same cycle.
  assign w_push     = w_port_hit && (r_state == ST_RUN) && !w_full;
  assign w_pop      = dport_write && dport_ready;

  assign dport_write = (r_count != '0);
  assign dport_out   = r_mem[r_rd_ptr];
  assign bus_stall   = w_full && (r_state == ST_RUN);
  assign done        = r_done;
  assign err         = r_err;
  assign emitted     = r_emitted;

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= bus_wdata;
        r_wr_ptr        <= r_wr_ptr + C_P_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_P_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Next-state logic for the end-of-program sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_done_hit) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (r_count == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // State register and sticky status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (w_state_nxt == ST_DONE);
      if (w_port_hit && (r_state != ST_RUN)) begin
        r_err <= 1'b1;
      end
    end
  end

  // Saturating count of bytes handed to the sink
  always_ff @(posedge clk) begin
    if (reset) begin
      r_emitted <= 9'h000;
    end else if (w_pop && (r_emitted != 9'h1FF)) begin
      r_emitted <= r_emitted + 9'h001;
    end
  end

endmodule

// File: tb/tb_dport_ctrl.sv
// Randomized self-checking bench for dport_ctrl against a queue-based reference model.
module tb_dport_ctrl;

  localparam int          DEPTH = 16;
  localparam logic [15:0] PORT  = 16'hFFF0;
  localparam logic [15:0] DONEA = 16'hFFF1;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic        bus_stall;
  logic [7:0]  dport_out;
  logic        dport_write;
  logic        dport_ready;
  logic        done;
  logic        err;
  logic [8:0]  emitted;

  always #5 clk = ~clk;

  dport_ctrl #(.DEPTH(DEPTH), .PORT_ADDR(PORT), .DONE_ADDR(DONEA)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_stall(bus_stall), .dport_out(dport_out),
    .dport_write(dport_write), .dport_ready(dport_ready), .done(done),
    .err(err), .emitted(emitted)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: 0 = running, 1 = end requested, 2 = ended
  logic [7:0] q[$];
  int         m_state;
  bit         m_err;
  int         m_emit;
  bit         m_acc;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_err   = 1'b0;
    m_emit  = 0;
    m_acc   = 1'b1;
  endtask

  task automatic model_step();
    bit port_hit, done_hit, full, pop, push;
    port_hit = bus_we && bus_addr == PORT;
    done_hit = bus_we && bus_addr == DONEA;
    full     = q.size() == DEPTH;
    pop      = q.size() > 0 && dport_ready;
    push     = port_hit && m_state == 0 && !full;
    m_acc    = !(port_hit && m_state == 0 && full);
    if (port_hit && m_state != 0) m_err = 1'b1;
    if (m_state == 0 && done_hit) m_state = 1;
    else if (m_state == 1 && q.size() == 0) m_state = 2;
    if (pop) begin
      void'(q.pop_front());
      if (m_emit < 511) m_emit++;
    end
    if (push) q.push_back(bus_wdata);
  endtask

  task automatic check_outputs();
    check_val("write", dport_write, q.size() > 0);
    if (q.size() > 0) check_val("data", dport_out, q[0]);
    check_val("stall", bus_stall, q.size() == DEPTH && m_state == 0);
    check_val("done", done, m_state == 2);
    check_val("err", err, m_err);
    check_val("emitted", emitted, m_emit);
  endtask

  // one clock: drive at negedge, update model at posedge, compare at next negedge
  task automatic cyc(input bit we, input logic [15:0] a, input logic [7:0] d, input bit rdy);
    bus_we      = we;
    bus_addr    = a;
    bus_wdata   = d;
    dport_ready = rdy;
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic store(input logic [15:0] a, input logic [7:0] d, input bit rdy);
    for (int t = 0; t < 64; t++) begin
      cyc(1'b1, a, d, rdy);
      if (m_acc) return;
    end
    check_val("store_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0000, 8'h00, rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 16'h0000, 8'h00, 1'b0);
    reset = 1'b0;
    check_val("rst_out", dport_out, 8'h00);
    check_val("rst_write", dport_write, 1'b0);
  endtask

  task automatic random_stream(input int nstores, input bit toggle, output int sent);
    logic [7:0] dat;
    bit         rdy;
    bit         refused;
    int         guard;
    sent    = 0;
    rdy     = 1'b0;
    refused = 1'b0;
    guard   = 0;
    dat     = 8'($urandom);
    while (sent < nstores && guard < 8000) begin
      guard++;
      rdy = toggle ? ~rdy : 1'($urandom);
      if (!refused && $urandom_range(0, 3) == 0) begin
        cyc(1'($urandom), 16'hFF00 | 16'($urandom_range(0, 15)) & 16'hFFFE | 16'h0002,
            8'($urandom), rdy);
      end else begin
        cyc(1'b1, PORT, dat, rdy);
        refused = !m_acc;
        if (m_acc) begin
          sent++;
          dat = 8'($urandom);
        end
      end
    end
    check_val("stream_sent", sent, nstores);
  endtask

  initial begin
    int sent;
    reset       = 1'b1;
    bus_we      = 1'b0;
    bus_addr    = 16'h0000;
    bus_wdata   = 8'h00;
    dport_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // two bytes straight through
    do_reset();
    cyc(1'b1, PORT, 8'hA5, 1'b1);
    check_val("t1_write", dport_write, 1'b1);
    check_val("t1_a5", dport_out, 8'hA5);
    cyc(1'b1, PORT, 8'h3C, 1'b1);
    check_val("t1_3c", dport_out, 8'h3C);
    idle(3, 1'b1);
    check_val("t1_emit", emitted, 9'd2);

    // fill to full, 17th store held until the sink drains
    do_reset();
    for (int i = 0; i < 16; i++) store(PORT, 8'(i), 1'b0);
    check_val("t2_stall", bus_stall, 1'b1);
    cyc(1'b1, PORT, 8'h10, 1'b0);
    cyc(1'b1, PORT, 8'h10, 1'b0);
    check_val("t2_held", emitted, 9'd0);
    store(PORT, 8'h10, 1'b1);
    idle(24, 1'b1);
    check_val("t2_emit", emitted, 9'd17);

    // end request with bytes still queued
    do_reset();
    for (int i = 0; i < 3; i++) store(PORT, 8'(8'h70 + i), 1'b0);
    store(DONEA, 8'hEE, 1'b0);
    idle(4, 1'b0);
    check_val("t3_notdone", done, 1'b0);
    idle(6, 1'b1);
    check_val("t3_done", done, 1'b1);
    check_val("t3_emit", emitted, 9'd3);

    // end request on an empty FIFO, then a late port store
    do_reset();
    cyc(1'b1, DONEA, 8'h00, 1'b1);
    check_val("t4_d1", done, 1'b0);
    cyc(1'b0, 16'h0000, 8'h00, 1'b1);
    check_val("t4_d2", done, 1'b1);
    cyc(1'b1, PORT, 8'h55, 1'b1);
    check_val("t5_err", err, 1'b1);
    idle(2, 1'b1);
    check_val("t5_write", dport_write, 1'b0);
    check_val("t5_emit", emitted, 9'd0);

    // long stream with toggling ready, counter saturation
    do_reset();
    random_stream(600, 1'b1, sent);
    idle(40, 1'b1);
    check_val("t6_sat", emitted, 9'h1FF);

    // reset while full and stalled
    do_reset();
    random_stream(40, 1'b0, sent);
    for (int i = 0; i < 20; i++) cyc(1'b1, PORT, 8'($urandom), 1'b0);
    do_reset();
    check_val("t7_stall", bus_stall, 1'b0);
    check_val("t7_emit", emitted, 9'd0);
    check_val("t7_done", done, 1'b0);
    check_val("t7_err", err, 1'b0);
    store(PORT, 8'h9B, 1'b0);
    check_val("t7_first", dport_out, 8'h9B);
    idle(3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
